// File: rtl/net_router_output_ctrl_pkt.sv
// Router output-port controller: round-robin wormhole arbiter
// with a domain-owned link and a dead gap on domain change.
module net_router_output_ctrl_pkt #(
  parameter int p_num_ports  = 3,
  parameter int p_sel_nbits  = $clog2(p_num_ports),
  parameter int p_dom_nbits  = 1,
  parameter int p_switch_gap = 2,
  parameter int p_gap_nbits  = $clog2(p_switch_gap+1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [p_num_ports-1:0]             reqs,
  input  logic [p_num_ports-1:0]             reqs_tail,
  input  logic [p_num_ports*p_dom_nbits-1:0] reqs_domain,
  input  logic                               out_rdy,
  output logic [p_num_ports-1:0]             grants,
  output logic                               out_val,
  output logic [p_sel_nbits-1:0]             xbar_sel,
  output logic [p_dom_nbits-1:0]             out_domain,
  output logic                               busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOCKED,
    ST_SWITCH
  } state_e;

  localparam logic [p_sel_nbits-1:0] LAST =
    p_sel_nbits'(p_num_ports-1);

  state_e                 state_q, state_d;
  logic [p_sel_nbits-1:0] lock_port_q, lock_port_d;
  logic [p_sel_nbits-1:0] ptr_q, ptr_d;
  logic [p_dom_nbits-1:0] out_domain_q, out_domain_d;
  logic [p_gap_nbits-1:0] gap_cnt_q, gap_cnt_d;
  logic [p_sel_nbits-1:0] xbar_sel_q, xbar_sel_d;

  logic [p_dom_nbits-1:0] dom_arr [p_num_ports];
  logic [p_sel_nbits-1:0] win;
  logic [p_sel_nbits-1:0] idx;
  logic [p_sel_nbits-1:0] win_inc;
  logic [p_sel_nbits-1:0] lock_inc;
  logic [p_dom_nbits-1:0] dom_w;
  logic                   found;
  logic [p_num_ports-1:0] grants_c;

  // Unpack per-port domain tags
  always_comb begin
    for (int i = 0; i < p_num_ports; i++) begin
      dom_arr[i] = reqs_domain[i*p_dom_nbits +: p_dom_nbits];
    end
  end

  // Round-robin pick starting at ptr
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < p_num_ports; k++) begin
      idx = p_sel_nbits'((int'(ptr_q) + k) % p_num_ports);
      if (!found && reqs[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign dom_w    = dom_arr[win];
  assign win_inc  = (win == LAST) ? '0 : win + 1'b1;
  assign lock_inc = (lock_port_q == LAST) ? '0
                  : lock_port_q + 1'b1;

  // Next state, grants and register updates
  always_comb begin
    state_d      = state_q;
    lock_port_d  = lock_port_q;
    ptr_d        = ptr_q;
    out_domain_d = out_domain_q;
    gap_cnt_d    = gap_cnt_q;
    xbar_sel_d   = xbar_sel_q;
    grants_c     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          if (dom_w == out_domain_q) begin
            if (out_rdy) begin
              grants_c[win] = 1'b1;
              xbar_sel_d    = win;
              if (reqs_tail[win]) begin
                ptr_d = win_inc;
              end else begin
                lock_port_d = win;
                state_d     = ST_LOCKED;
              end
            end
          end else begin
            out_domain_d = dom_w;
            lock_port_d  = win;
            gap_cnt_d    = p_gap_nbits'(p_switch_gap-1);
            state_d      = ST_SWITCH;
          end
        end
      end
      ST_SWITCH: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end else begin
          state_d    = ST_LOCKED;
          xbar_sel_d = lock_port_q;
        end
      end
      ST_LOCKED: begin
        if (reqs[lock_port_q] && out_rdy) begin
          grants_c[lock_port_q] = 1'b1;
          if (reqs_tail[lock_port_q]) begin
            state_d = ST_IDLE;
            ptr_d   = lock_inc;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (reset) grants_c = '0;
  end

  // State registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      lock_port_q  <= '0;
      ptr_q        <= '0;
      out_domain_q <= '0;
      gap_cnt_q    <= '0;
      xbar_sel_q   <= '0;
    end else begin
      state_q      <= state_d;
      lock_port_q  <= lock_port_d;
      ptr_q        <= ptr_d;
      out_domain_q <= out_domain_d;
      gap_cnt_q    <= gap_cnt_d;
      xbar_sel_q   <= xbar_sel_d;
    end
  end

  assign grants     = grants_c;
  assign out_val    = |grants_c;
  assign xbar_sel   = xbar_sel_q;
  assign out_domain = out_domain_q;
  assign busy       = (state_q != ST_IDLE) && !reset;

endmodule

// File: tb/tb_net_router_output_ctrl_pkt.sv
// Bench for net_router_output_ctrl_pkt: directed packets
// checked against a packet-level model plus literal pins.
module tb_net_router_output_ctrl_pkt;

  localparam int N = 3;
  localparam int S = 2;
  localparam int D = 1;
  localparam int G = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] reqs;
  logic [N-1:0] reqs_tail;
  logic [N*D-1:0] reqs_domain;
  logic         out_rdy;
  logic [N-1:0] grants;
  logic         out_val;
  logic [S-1:0] xbar_sel;
  logic [D-1:0] out_domain;
  logic         busy;

  int n_pass = 0;
  int n_total = 0;

  net_router_output_ctrl_pkt #(
    .p_num_ports (N),
    .p_sel_nbits (S),
    .p_dom_nbits (D),
    .p_switch_gap(G),
    .p_gap_nbits ($clog2(G+1))
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .reqs       (reqs),
    .reqs_tail  (reqs_tail),
    .reqs_domain(reqs_domain),
    .out_rdy    (out_rdy),
    .grants     (grants),
    .out_val    (out_val),
    .xbar_sel   (xbar_sel),
    .out_domain (out_domain),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act,
                     input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
  endtask

  // ---------------- packet-level model ----------------
  int m_owner = -1;  // port holding the link, -1 none
  int m_gap   = 0;   // dead cycles still to spend
  int m_ptr   = 0;
  int m_dom   = 0;
  int m_sel   = 0;

  function automatic int dom_of(input int p);
    return int'((reqs_domain >> (p*D)) & ((1 << D) - 1));
  endfunction

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      if (reqs[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  initial begin
    @(posedge clk);
    forever begin
      int eg;
      int eb;
      int w;
      @(negedge clk);
      eg = 0;
      eb = 0;
      w  = -1;
      if (!reset) begin
        if (m_gap > 0) begin
          eb = 1;
        end else if (m_owner >= 0) begin
          eb = 1;
          if (reqs[m_owner] && out_rdy) eg = 1 << m_owner;
        end else begin
          w = pick();
          if (w >= 0 && dom_of(w) == m_dom && out_rdy)
            eg = 1 << w;
        end
      end
      chk("m_grants", int'(grants), eg);
      chk("m_out_val", int'(out_val), int'(eg != 0));
      chk("m_xbar_sel", int'(xbar_sel), m_sel);
      chk("m_out_domain", int'(out_domain), m_dom);
      chk("m_busy", int'(busy), eb);
      if (reset) begin
        m_owner = -1;
        m_gap = 0;
        m_ptr = 0;
        m_dom = 0;
        m_sel = 0;
      end else if (m_gap > 0) begin
        m_gap--;
        if (m_gap == 0) m_sel = m_owner;
      end else if (m_owner >= 0) begin
        if (eg != 0 && reqs_tail[m_owner]) begin
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
        end
      end else if (w >= 0) begin
        if (dom_of(w) == m_dom) begin
          if (out_rdy) begin
            m_sel = w;
            if (reqs_tail[w]) m_ptr = (w + 1) % N;
            else m_owner = w;
          end
        end else begin
          m_dom = dom_of(w);
          m_owner = w;
          m_gap = G;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [N-1:0] r,
                       input logic [N-1:0] t,
                       input logic [N*D-1:0] d,
                       input logic rdy);
    reqs = r;
    reqs_tail = t;
    reqs_domain = d;
    out_rdy = rdy;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rr_g [4];
    int rr_s [4];
    rr_g = '{1, 2, 4, 1};
    rr_s = '{0, 0, 1, 2};
    reset = 1'b1;
    drive('0, '0, '0, 1'b1);
    chk("rst_grants", int'(grants), 0);
    chk("rst_busy", int'(busy), 0);
    adv();
    @(negedge clk);
    adv();
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      drive('0, '0, '0, 1'b1);
      chk("idle_grants", int'(grants), 0);
      chk("idle_sel", int'(xbar_sel), 0);
      chk("idle_busy", int'(busy), 0);
      adv();
    end

    for (int i = 0; i < 4; i++) begin
      drive(3'b111, 3'b111, 3'b000, 1'b1);
      chk("rr_grants", int'(grants), rr_g[i]);
      chk("rr_sel", int'(xbar_sel), rr_s[i]);
      chk("rr_val", int'(out_val), 1);
      adv();
    end
    drive('0, '0, '0, 1'b1);
    chk("rr_sel_last", int'(xbar_sel), 0);
    adv();

    drive(3'b011, 3'b001, 3'b000, 1'b1);
    chk("pkt_f1", int'(grants), 2);
    adv();
    drive(3'b011, 3'b001, 3'b000, 1'b0);
    chk("pkt_stall", int'(grants), 0);
    chk("pkt_stall_busy", int'(busy), 1);
    adv();
    drive(3'b011, 3'b001, 3'b000, 1'b1);
    chk("pkt_f2", int'(grants), 2);
    adv();
    drive(3'b011, 3'b001, 3'b000, 1'b1);
    chk("pkt_f3", int'(grants), 2);
    adv();
    drive(3'b011, 3'b011, 3'b000, 1'b1);
    chk("pkt_tail", int'(grants), 2);
    adv();
    drive(3'b001, 3'b001, 3'b000, 1'b1);
    chk("pkt_next", int'(grants), 1);
    adv();
    drive('0, '0, '0, 1'b1);
    adv();

    drive(3'b100, 3'b100, 3'b100, 1'b1);
    chk("sw_detect", int'(grants), 0);
    adv();
    drive(3'b100, 3'b100, 3'b100, 1'b1);
    chk("sw_gap1", int'(out_val), 0);
    chk("sw_gap1_dom", int'(out_domain), 1);
    adv();
    drive(3'b100, 3'b100, 3'b100, 1'b1);
    chk("sw_gap2", int'(out_val), 0);
    adv();
    drive(3'b100, 3'b100, 3'b100, 1'b1);
    chk("sw_grant", int'(grants), 4);
    chk("sw_sel", int'(xbar_sel), 2);
    adv();
    drive('0, '0, '0, 1'b1);
    adv();

    for (int i = 0; i < 3; i++) begin
      drive(3'b001, 3'b000, 3'b000, 1'b1);
      chk("mid_gap", int'(grants), 0);
      adv();
    end
    drive(3'b001, 3'b000, 3'b000, 1'b1);
    chk("mid_f1", int'(grants), 1);
    chk("mid_f1_dom", int'(out_domain), 0);
    adv();
    drive(3'b001, 3'b000, 3'b001, 1'b1);
    chk("mid_f2", int'(grants), 1);
    chk("mid_f2_dom", int'(out_domain), 0);
    adv();
    drive(3'b000, 3'b000, 3'b001, 1'b1);
    chk("mid_bubble", int'(grants), 0);
    chk("mid_bubble_busy", int'(busy), 1);
    adv();
    drive(3'b001, 3'b001, 3'b001, 1'b1);
    chk("mid_tail", int'(grants), 1);
    adv();
    drive('0, '0, '0, 1'b1);
    chk("mid_after_busy", int'(busy), 0);
    chk("mid_after_dom", int'(out_domain), 0);
    adv();

    drive(3'b010, 3'b010, 3'b010, 1'b1);
    chk("rg_detect", int'(grants), 0);
    adv();
    reset = 1'b1;
    drive(3'b010, 3'b010, 3'b010, 1'b1);
    chk("rg_in_reset", int'(grants), 0);
    adv();
    reset = 1'b0;
    drive('0, '0, '0, 1'b1);
    chk("rg_dom", int'(out_domain), 0);
    chk("rg_busy", int'(busy), 0);
    chk("rg_grants", int'(grants), 0);
    adv();
    drive(3'b111, 3'b111, 3'b000, 1'b1);
    chk("rg_ptr0", int'(grants), 1);
    adv();

    drive(3'b100, 3'b100, 3'b100, 1'b0);
    chk("nr_detect", int'(grants), 0);
    adv();
    drive(3'b100, 3'b100, 3'b100, 1'b0);
    chk("nr_dom", int'(out_domain), 1);
    adv();
    drive(3'b100, 3'b100, 3'b100, 1'b1);
    chk("nr_gap2", int'(grants), 0);
    adv();
    drive(3'b100, 3'b100, 3'b100, 1'b1);
    chk("nr_grant", int'(grants), 4);
    adv();
    drive('0, '0, '0, 1'b1);
    adv();
    drive('0, '0, '0, 1'b1);
    adv();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
